// File: rtl/cpu_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BR,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h7;
  localparam logic [3:0] OP_BN   = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] IMM_5  = 2'b00;
  localparam logic [1:0] IMM_8  = 2'b01;
  localparam logic [1:0] IMM_11 = 2'b10;

  typedef struct packed {
    logic       readins;
    logic       top_id;
    logic       trans1_pc;
    logic       trans2_pc;
    logic       ld_pc;
    logic       read1;
    logic       read2;
    logic       write;
    logic       trans_x1;
    logic       trans_x2;
    logic       trans_x3;
    logic       trans_y1;
    logic       trans_y2;
    logic       trans_y3;
    logic [2:0] func_select;
    logic       trans_alu_z;
    logic       trans_yz;
    logic       tdz;
    logic       read_data;
    logic       write_data;
    logic [1:0] imm_sel;
    logic       halted;
  } ctrl_t;

  function automatic logic [1:0] imm_sel_of(input logic [3:0] op);
    case (op)
      OP_BZ, OP_BN: return IMM_8;
      OP_J:         return IMM_11;
      default:      return IMM_5;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_decode.sv
// Combinational control-vector decode from FSM state, opcode and latched flags.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       z_flag,
  input  logic       s_flag,
  output ctrl_t      ctrl
);

  logic br_taken;

  assign br_taken = (opcode == OP_J) ||
                    ((opcode == OP_BZ) && z_flag) ||
                    ((opcode == OP_BN) && s_flag);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.readins   = 1'b1;
        ctrl.top_id    = 1'b1;
        ctrl.trans1_pc = 1'b1;
        ctrl.ld_pc     = 1'b1;
      end
      S_DECODE: begin
        ctrl.read1   = 1'b1;
        ctrl.read2   = 1'b1;
        ctrl.imm_sel = imm_sel_of(opcode);
      end
      S_EXEC: begin
        ctrl.trans_x1    = 1'b1;
        ctrl.trans_alu_z = 1'b1;
        // R-type opcodes 0-3 share their low bits with the ALU op encoding
        if (opcode <= OP_OR) begin
          ctrl.trans_y1    = 1'b1;
          ctrl.func_select = {1'b0, opcode[1:0]};
        end else begin
          ctrl.trans_y2    = 1'b1;
          ctrl.func_select = ALU_ADD;
          ctrl.imm_sel     = IMM_5;
        end
      end
      S_MEM: begin
        ctrl.read_data  = (opcode == OP_LD);
        ctrl.write_data = (opcode == OP_ST);
      end
      S_WB: begin
        ctrl.write = 1'b1;
        if (opcode == OP_LD) ctrl.tdz = 1'b1;
        else                 ctrl.trans_alu_z = 1'b1;
      end
      S_BR: begin
        if (br_taken) begin
          ctrl.trans_x2    = 1'b1;
          ctrl.trans_y2    = 1'b1;
          ctrl.func_select = ALU_ADD;
          ctrl.trans_alu_z = 1'b1;
          ctrl.trans2_pc   = 1'b1;
          ctrl.ld_pc       = 1'b1;
          ctrl.imm_sel     = imm_sel_of(opcode);
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM; optional retired-instruction counter under CTRL_PERF_CNT_EN.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned ISA_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ISA_W-1:0] ins_out,
  input  logic             Zin,
  input  logic             Vin,
  input  logic             Sin,
  input  logic             Cin,
  output logic             readins,
  output logic             TopID,
  output logic             Trans1PC,
  output logic             Trans2PC,
  output logic             ldPC,
  output logic             read1,
  output logic             read2,
  output logic             write,
  output logic             TransX1,
  output logic             TransX2,
  output logic             TransX3,
  output logic             TransY1,
  output logic             TransY2,
  output logic             TransY3,
  output logic [2:0]       func_select,
  output logic             Trans_ALU_Z,
  output logic             TransYZ,
  output logic             TDZ,
  output logic             readData,
  output logic             writeData,
  output logic [1:0]       imm_sel,
  output logic             halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]      retired_cnt
`endif
);

  state_t           state, state_d;
  logic [ISA_W-1:0] ir;
  logic [3:0]       opcode;
  logic             z_flag, s_flag, v_flag, c_flag;
  logic [3:0]       wait_cnt;
  ctrl_t            ctrl;

  assign opcode = ir[ISA_W-1:ISA_W-4];

  // Operand fields and V/C flags are kept for the datapath but not consumed here
  logic unused_bits;
  assign unused_bits = ^{ir[ISA_W-5:0], v_flag, c_flag};

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_HALT:                    state_d = S_HALT;
          OP_J, OP_BZ, OP_BN:         state_d = S_BR;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_LD, OP_ST:      state_d = S_EXEC;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = (opcode == OP_LD || opcode == OP_ST) ? S_MEM : S_WB;
      S_MEM: begin
        if (wait_cnt == '0) state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB, S_BR: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      z_flag   <= 1'b0;
      s_flag   <= 1'b0;
      v_flag   <= 1'b0;
      c_flag   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == S_FETCH) ir <= ins_out;
      if (state == S_EXEC && opcode <= OP_ADDI) begin
        z_flag <= Zin;
        s_flag <= Sin;
        v_flag <= Vin;
        c_flag <= Cin;
      end
      // Counter is preloaded so S_MEM lasts exactly MEM_WAIT cycles
      if (state == S_EXEC)                        wait_cnt <= 4'(MEM_WAIT - 1);
      else if (state == S_MEM && wait_cnt != '0)  wait_cnt <= wait_cnt - 4'd1;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Every return to S_FETCH other than the one out of S_IDLE retires an instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        retired_cnt <= '0;
    else if (state_d == S_FETCH && state != S_IDLE) retired_cnt <= retired_cnt + 16'd1;
  end
`endif

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .z_flag (z_flag),
    .s_flag (s_flag),
    .ctrl   (ctrl)
  );

  assign readins     = ctrl.readins;
  assign TopID       = ctrl.top_id;
  assign Trans1PC    = ctrl.trans1_pc;
  assign Trans2PC    = ctrl.trans2_pc;
  assign ldPC        = ctrl.ld_pc;
  assign read1       = ctrl.read1;
  assign read2       = ctrl.read2;
  assign write       = ctrl.write;
  assign TransX1     = ctrl.trans_x1;
  assign TransX2     = ctrl.trans_x2;
  assign TransX3     = ctrl.trans_x3;
  assign TransY1     = ctrl.trans_y1;
  assign TransY2     = ctrl.trans_y2;
  assign TransY3     = ctrl.trans_y3;
  assign func_select = ctrl.func_select;
  assign Trans_ALU_Z = ctrl.trans_alu_z;
  assign TransYZ     = ctrl.trans_yz;
  assign TDZ         = ctrl.tdz;
  assign readData    = ctrl.read_data;
  assign writeData   = ctrl.write_data;
  assign imm_sel     = ctrl.imm_sel;
  assign halted      = ctrl.halted;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm against a cycle-indexed instruction model.
module tb_cpu_control_fsm;

  localparam int unsigned MEM_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ins_out;
  logic        Zin, Vin, Sin, Cin;
  logic        readins, TopID, Trans1PC, Trans2PC, ldPC, read1, read2, write;
  logic        TransX1, TransX2, TransX3, TransY1, TransY2, TransY3;
  logic [2:0]  func_select;
  logic        Trans_ALU_Z, TransYZ, TDZ, readData, writeData, halted;
  logic [1:0]  imm_sel;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  cpu_control_fsm #(.MEM_WAIT(MEM_WAIT), .ISA_W(16)) dut (
    .clk(clk), .rst(rst), .ins_out(ins_out),
    .Zin(Zin), .Vin(Vin), .Sin(Sin), .Cin(Cin),
    .readins(readins), .TopID(TopID), .Trans1PC(Trans1PC), .Trans2PC(Trans2PC),
    .ldPC(ldPC), .read1(read1), .read2(read2), .write(write),
    .TransX1(TransX1), .TransX2(TransX2), .TransX3(TransX3),
    .TransY1(TransY1), .TransY2(TransY2), .TransY3(TransY3),
    .func_select(func_select), .Trans_ALU_Z(Trans_ALU_Z), .TransYZ(TransYZ),
    .TDZ(TDZ), .readData(readData), .writeData(writeData),
    .imm_sel(imm_sel), .halted(halted)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  typedef struct packed {
    logic       readins, top_id, trans1_pc, trans2_pc, ld_pc, read1, read2, write;
    logic       x1, x2, x3, y1, y2, y3;
    logic [2:0] func;
    logic       alu_z, yz, tdz, rd, wd;
    logic [1:0] imm;
    logic       halted;
  } vec_t;

  vec_t act;
  assign act = {readins, TopID, Trans1PC, Trans2PC, ldPC, read1, read2, write,
                TransX1, TransX2, TransX3, TransY1, TransY2, TransY3,
                func_select, Trans_ALU_Z, TransYZ, TDZ, readData, writeData,
                imm_sel, halted};

  int errors = 0;
  int checks = 0;

  // Reference state: architectural flags and instructions retired since reset
  bit zf, sf;
  int retired;
  bit force_flags;
  bit fz, fs;

  task automatic check(input string tag, input vec_t exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_count(input string tag);
`ifdef CTRL_PERF_CNT_EN
    checks++;
    assert (retired_cnt === 16'(retired)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, retired_cnt, retired);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h1:    return 3'b001;
      4'h2:    return 3'b010;
      4'h3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_code(input logic [3:0] op);
    if (op == 4'h7 || op == 4'h8) return 2'b01;
    if (op == 4'h9)               return 2'b10;
    return 2'b00;
  endfunction

  // Entered at the sample point of the instruction's FETCH cycle; stop_after > 0 returns
  // early (still inside that cycle) after checking that many cycles.
  task automatic run_instr(input logic [15:0] word, input int stop_after);
    logic [3:0] op;
    int         len;
    bit         is_br, taken;
    vec_t       e;
    op    = word[15:12];
    is_br = (op == 4'h7 || op == 4'h8 || op == 4'h9);
    if (op <= 4'h4)      len = 4;
    else if (op == 4'h5) len = 4 + MEM_WAIT;
    else if (op == 4'h6) len = 3 + MEM_WAIT;
    else if (is_br)      len = 3;
    else if (op == 4'hF) len = 2 + 20;
    else                 len = 2;
    taken = (op == 4'h9) || (op == 4'h7 && zf) || (op == 4'h8 && sf);
    check_count($sformatf("retired_op%h", op));
    for (int k = 0; k < len; k++) begin
      e = '0;
      if (k == 0) begin
        e.readins = 1; e.top_id = 1; e.trans1_pc = 1; e.ld_pc = 1;
      end else if (k == 1) begin
        e.read1 = 1; e.read2 = 1; e.imm = imm_code(op);
      end else if (op == 4'hF) begin
        e.halted = 1;
      end else if (is_br) begin
        if (taken) begin
          e.x2 = 1; e.y2 = 1; e.alu_z = 1; e.trans2_pc = 1; e.ld_pc = 1;
          e.imm = imm_code(op);
        end
      end else if (k == 2) begin
        e.x1 = 1; e.alu_z = 1; e.func = alu_code(op);
        if (op <= 4'h3) e.y1 = 1;
        else            e.y2 = 1;
      end else if ((op == 4'h5 || op == 4'h6) && k < 3 + MEM_WAIT) begin
        e.rd = (op == 4'h5);
        e.wd = (op == 4'h6);
      end else begin
        e.write = 1;
        if (op == 4'h5) e.tdz = 1;
        else            e.alu_z = 1;
      end
      check($sformatf("op%h_cyc%0d", op, k), e);

      ins_out = (k == 0) ? word : 16'($urandom);
      if (force_flags && k == 2) begin
        Zin = fz; Sin = fs;
      end else begin
        Zin = 1'($urandom_range(0, 1));
        Sin = 1'($urandom_range(0, 1));
      end
      Vin = 1'($urandom_range(0, 1));
      Cin = 1'($urandom_range(0, 1));
      if (k == 2 && op <= 4'h4) begin
        zf = Zin; sf = Sin;
      end
      if (stop_after > 0 && k + 1 == stop_after) return;
      @(posedge clk); #1;
    end
    if (op != 4'hF) retired++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_held", '0);
    end
    rst = 1'b0;
    zf = 0; sf = 0; retired = 0;
    check("idle", '0);
    check_count("retired_reset");
    @(posedge clk); #1;
  endtask

  initial begin
    ins_out = '0; Zin = 0; Vin = 0; Sin = 0; Cin = 0;
    force_flags = 0; fz = 0; fs = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // LD aborted by reset while in the memory phase
    run_instr(16'h5123, 4);
    do_reset();

    // SUB sets Z=1, S=0; BZ taken, BN not taken
    force_flags = 1; fz = 1; fs = 0;
    run_instr(16'h1234, 0);
    force_flags = 0;
    run_instr(16'h70F3, 0);
    run_instr(16'h8011, 0);

    run_instr(16'h5ABC, 0);
    run_instr(16'h6DEF, 0);
    run_instr(16'h4321, 0);
    run_instr(16'h0111, 0);
    run_instr(16'h2222, 0);
    run_instr(16'h3333, 0);
    run_instr(16'h9ABC, 0);
    run_instr(16'hA000, 0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, 0);
    end

    run_instr(16'hF000, 0);
    check_count("retired_after_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
